// File: rtl/line_scan_walker.sv
// line_scan_walker: walks the integer pixel bounding box of a Q10.10 segment
// in raster order, presents each pixel to an external line test, and emits a
// valid/ready pixel write for every pixel the test reports as on the line.
module line_scan_walker #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int FRAC  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vtx_valid,
    output logic        vtx_ready,
    input  logic [20:0] vtxA_X,
    input  logic [20:0] vtxA_Y,
    input  logic [20:0] vtxB_X,
    input  logic [20:0] vtxB_Y,
    output logic [20:0] h_cnt_Q,
    output logic [20:0] v_cnt_Q,
    input  logic        onLine,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SCAN  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic signed [20:0] X_MAX_C = 21'(H_RES - 1);
    localparam logic signed [20:0] Y_MAX_C = 21'(V_RES - 1);

    state_t             state_r;
    state_t             state_next_s;

    // Endpoints latched on accept; never touched again until the next accept.
    logic signed [20:0] a_x_r;
    logic signed [20:0] a_y_r;
    logic signed [20:0] b_x_r;
    logic signed [20:0] b_y_r;

    // Scan position and clipped box limits (minimum y is only needed at load).
    logic [9:0]         x_r;
    logic [9:0]         y_r;
    logic [9:0]         min_x_r;
    logic [9:0]         max_x_r;
    logic [9:0]         max_y_r;

    logic               pix_valid_r;
    logic [9:0]         pix_x_r;
    logic [9:0]         pix_y_r;
    logic               vtx_ready_r;
    logic               busy_r;
    logic               done_r;

    logic signed [20:0] min_x_raw_s;
    logic signed [20:0] max_x_raw_s;
    logic signed [20:0] min_y_raw_s;
    logic signed [20:0] max_y_raw_s;
    logic signed [20:0] lo_x_s;
    logic signed [20:0] hi_x_s;
    logic signed [20:0] lo_y_s;
    logic signed [20:0] hi_y_s;
    logic               empty_s;
    logic               accept_s;
    logic               slot_free_s;
    logic               scan_adv_s;
    logic               last_pix_s;

    assign accept_s    = vtx_valid && vtx_ready_r;
    assign slot_free_s = !pix_valid_r || pix_ready;
    assign scan_adv_s  = (state_r == SCAN) && slot_free_s;
    assign last_pix_s  = (x_r == max_x_r) && (y_r == max_y_r);

    // The line test sees the scan position as a Q10.10 value with zero fraction.
    assign h_cnt_Q   = {11'd0, x_r} << FRAC;
    assign v_cnt_Q   = {11'd0, y_r} << FRAC;
    assign pix_valid = pix_valid_r;
    assign pix_x     = pix_x_r;
    assign pix_y     = pix_y_r;
    assign vtx_ready = vtx_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Floor the endpoint extremes to integers and clip the box to the screen.
    always_comb begin
        min_x_raw_s = ((a_x_r < b_x_r) ? a_x_r : b_x_r) >>> FRAC;
        max_x_raw_s = ((a_x_r < b_x_r) ? b_x_r : a_x_r) >>> FRAC;
        min_y_raw_s = ((a_y_r < b_y_r) ? a_y_r : b_y_r) >>> FRAC;
        max_y_raw_s = ((a_y_r < b_y_r) ? b_y_r : a_y_r) >>> FRAC;
        if (min_x_raw_s < 21'sd0) begin
            lo_x_s = 21'sd0;
        end else begin
            lo_x_s = min_x_raw_s;
        end
        if (min_y_raw_s < 21'sd0) begin
            lo_y_s = 21'sd0;
        end else begin
            lo_y_s = min_y_raw_s;
        end
        if (max_x_raw_s > X_MAX_C) begin
            hi_x_s = X_MAX_C;
        end else begin
            hi_x_s = max_x_raw_s;
        end
        if (max_y_raw_s > Y_MAX_C) begin
            hi_y_s = Y_MAX_C;
        end else begin
            hi_y_s = max_y_raw_s;
        end
        empty_s = (lo_x_s > hi_x_s) || (lo_y_s > hi_y_s);
    end

    // Next-state logic for the segment walk.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                if (empty_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SCAN;
                end
            end
            SCAN: begin
                if (scan_adv_s && last_pix_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = SCAN;
                end
            end
            DRAIN: begin
                if (slot_free_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            vtx_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            vtx_ready_r <= (state_next_s == IDLE);
            busy_r      <= (state_next_s != IDLE);
            done_r      <= (state_next_s == DONE);
        end
    end

    // Endpoint latch, box setup and raster stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_x_r   <= 21'sd0;
            a_y_r   <= 21'sd0;
            b_x_r   <= 21'sd0;
            b_y_r   <= 21'sd0;
            x_r     <= 10'd0;
            y_r     <= 10'd0;
            min_x_r <= 10'd0;
            max_x_r <= 10'd0;
            max_y_r <= 10'd0;
        end else begin
            if (accept_s) begin
                a_x_r <= vtxA_X;
                a_y_r <= vtxA_Y;
                b_x_r <= vtxB_X;
                b_y_r <= vtxB_Y;
            end
            if ((state_r == SETUP) && !empty_s) begin
                x_r     <= lo_x_s[9:0];
                y_r     <= lo_y_s[9:0];
                min_x_r <= lo_x_s[9:0];
                max_x_r <= hi_x_s[9:0];
                max_y_r <= hi_y_s[9:0];
            end
            // The final pixel keeps its position so the line test input stays put.
            if (scan_adv_s && !last_pix_s) begin
                if (x_r == max_x_r) begin
                    x_r <= min_x_r;
                    y_r <= y_r + 10'd1;
                end else begin
                    x_r <= x_r + 10'd1;
                end
            end
        end
    end

    // Pixel write slot: load on an on-line advance, clear once the sink takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid_r <= 1'b0;
            pix_x_r     <= 10'd0;
            pix_y_r     <= 10'd0;
        end else if (scan_adv_s) begin
            if (onLine) begin
                pix_valid_r <= 1'b1;
                pix_x_r     <= x_r;
                pix_y_r     <= y_r;
            end else begin
                pix_valid_r <= 1'b0;
            end
        end else if (pix_valid_r && pix_ready) begin
            pix_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_scan_walker.sv
// Directed bench for line_scan_walker: horizontal, stalled, clipped, empty,
// single-pixel and reset-abort segments with hand-computed expectations.
module tb_line_scan_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        vtx_valid;
    logic        vtx_ready;
    logic [20:0] vtxA_X;
    logic [20:0] vtxA_Y;
    logic [20:0] vtxB_X;
    logic [20:0] vtxB_Y;
    logic [20:0] h_cnt_Q;
    logic [20:0] v_cnt_Q;
    logic        onLine;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        busy;
    logic        done;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    logic        line_mode = 1'b0;
    logic        pv_seen = 1'b0;
    logic        neg_seen = 1'b0;
    logic [19:0] wr_q[$];

    line_scan_walker #(.H_RES(640), .V_RES(480), .FRAC(10)) dut (
        .clk(clk), .rst(rst),
        .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
        .vtxA_X(vtxA_X), .vtxA_Y(vtxA_Y), .vtxB_X(vtxB_X), .vtxB_Y(vtxB_Y),
        .h_cnt_Q(h_cnt_Q), .v_cnt_Q(v_cnt_Q), .onLine(onLine),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .done(done)
    );

    // Line test stand-in: whole box for axis segments, main diagonal otherwise.
    assign onLine = line_mode ? (h_cnt_Q == v_cnt_Q) : 1'b1;

    always #5 clk = ~clk;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor sampling mid-cycle: accepts, done pulses, writes, flags.
    always @(negedge clk) begin
        if (vtx_valid && vtx_ready) acc_cyc = cyc;
        if (done) begin
            done_cyc = cyc;
            done_cnt = done_cnt + 1;
        end
        if (pix_valid && pix_ready) wr_q.push_back({pix_x, pix_y});
        if (pix_valid) pv_seen = 1'b1;
        if (h_cnt_Q[20] || v_cnt_Q[20]) neg_seen = 1'b1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total = total + 1;
        if (obs != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] q(input int v);
        return 21'(v * 1024);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a segment and return one cycle after the accepting edge.
    task automatic send_seg(input int ax, input int ay, input int bx, input int by);
        int n;
        n = 0;
        while (!vtx_ready && n < 50) begin
            step();
            n = n + 1;
        end
        if (!vtx_ready) chk("ready_timeout", 0, 1);
        vtx_A_drive(ax, ay, bx, by);
        vtx_valid = 1'b1;
        step();
        vtx_valid = 1'b0;
    endtask

    task automatic vtx_A_drive(input int ax, input int ay, input int bx, input int by);
        vtxA_X = q(ax);
        vtxA_Y = q(ay);
        vtxB_X = q(bx);
        vtxB_Y = q(by);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 400) begin
            step();
            n = n + 1;
        end
        if (!done) chk("done_timeout", 0, 1);
        step();
    endtask

    task automatic check_writes(input int x0, input int n, input int y);
        chk("wr_count", wr_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wr_q.size()) begin
                chk("wr_x", int'(wr_q[i][19:10]), x0 + i);
                chk("wr_y", int'(wr_q[i][9:0]), y);
            end
        end
    endtask

    initial begin
        int n;
        int dc;
        rst = 1'b1;
        vtx_valid = 1'b0;
        pix_ready = 1'b1;
        vtx_A_drive(0, 0, 0, 0);

        // Reset state.
        step(); step(); step();
        chk("rst_vtx_ready", vtx_ready, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_h_cnt", h_cnt_Q, 0);
        chk("rst_pix_x", pix_x, 0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", vtx_ready, 1);

        // Horizontal segment, sink always ready.
        wr_q.delete();
        send_seg(10, 5, 20, 5);
        chk("setup_busy", busy, 1);
        chk("setup_ready", vtx_ready, 0);
        step();
        chk("first_h", h_cnt_Q, 10 * 1024);
        chk("first_v", v_cnt_Q, 5 * 1024);
        chk("first_pv_early", pix_valid, 0);
        step();
        chk("first_pv", pix_valid, 1);
        chk("first_px", pix_x, 10);
        wait_done();
        chk("t1_latency", done_cyc - acc_cyc, 14);
        check_writes(10, 11, 5);
        chk("t1_ready_after", vtx_ready, 1);

        // Same segment with the sink stalled for five cycles.
        wr_q.delete();
        pix_ready = 1'b0;
        send_seg(10, 5, 20, 5);
        n = 0;
        while (!pix_valid && n < 20) begin
            step();
            n = n + 1;
        end
        for (int i = 0; i < 6; i++) begin
            chk("stall_pv", pix_valid, 1);
            chk("stall_px", pix_x, 10);
            if (i == 5) pix_ready = 1'b1;
            step();
        end
        wait_done();
        check_writes(10, 11, 5);

        // Left edge clipping.
        wr_q.delete();
        neg_seen = 1'b0;
        send_seg(-5, 3, 4, 3);
        step();
        chk("clip_first_h", h_cnt_Q, 0);
        wait_done();
        check_writes(0, 5, 3);
        chk("clip_no_neg", neg_seen, 0);

        // Box entirely off screen.
        wr_q.delete();
        pv_seen = 1'b0;
        send_seg(700, 500, 800, 600);
        wait_done();
        chk("off_latency", done_cyc - acc_cyc, 2);
        chk("off_no_pv", pv_seen, 0);
        chk("off_writes", wr_q.size(), 0);

        // Single pixel.
        wr_q.delete();
        send_seg(7, 7, 7, 7);
        wait_done();
        chk("pt_latency", done_cyc - acc_cyc, 4);
        check_writes(7, 1, 7);

        // Diagonal aborted by reset at the 20th scan cycle.
        wr_q.delete();
        line_mode = 1'b1;
        send_seg(0, 0, 15, 15);
        for (int i = 0; i < 20; i++) step();
        dc = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_pv", pix_valid, 0);
        chk("abort_px", pix_x, 0);
        chk("abort_py", pix_y, 0);
        chk("abort_h", h_cnt_Q, 0);
        chk("abort_v", v_cnt_Q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready0", vtx_ready, 0);
        step();
        chk("abort_ready1", vtx_ready, 1);
        chk("abort_no_done", done_cnt, dc);

        // New segment after the abort.
        wr_q.delete();
        line_mode = 1'b0;
        send_seg(3, 2, 6, 2);
        wait_done();
        chk("resume_latency", done_cyc - acc_cyc, 7);
        check_writes(3, 4, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
